stream_sync_fifo_framer: RTL and testbench



---
 rtl/stream_sync_fifo_framer.sv | 215 +++++++++++++++++++++
 tb/tb_stream_sync_fifo_framer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_sync_fifo_framer.sv
// -----------------------------------------------------------------------------
// stream_sync_fifo_framer
//
// Single-clock stream FIFO with speculative frame building. Words written on
// the write side stay invisible to the reader until the frame is committed,
// and a discard rolls them back. The first word of the open frame can be
// rewritten (HEAD / FINAL_HEAD) so a producer can fill in a header after the
// payload length is known. The read side is first-word-fall-through and
// carries a per-word end-of-frame marker.
//
// Optional feature macro: STREAM_FIFO_FRAME_COUNT_EN
//   defined   -> r_frames counts committed frames not yet fully read
//   undefined -> r_frames is tied to 0 and the counter is not built
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears all pointers)
//   w_ctrl     in   write command: 0 NOP, 1 WRITE, 2 EOF_WITH_WRITE,
//                   3 EOF_WITHOUT_WRITE, 4 HEAD, 5 FINAL_HEAD, 6 DISCARD,
//                   7 reserved (NOP)
//   din        in   write data
//   w_full     out  wptr - rptr == DEPTH (uncommitted words included)
//   w_error    out  registered pulse: illegal write command last edge
//   w_counter  out  wptr - rptr
//   r_en       in   pop the current word
//   r_valid    out  committed data available (rptr != cptr)
//   dout       out  mem[rptr], first-word-fall-through
//   r_last     out  end-of-frame flag of mem[rptr]
//   r_error    out  registered pulse: r_en seen while !r_valid
//   r_counter  out  cptr - rptr
//   r_frames   out  committed frames not yet fully read
//
// Read handshake: r_valid/dout/r_last describe the head word; a word is
// consumed on a rising edge where r_en && r_valid. r_en without r_valid is
// an error (r_error next cycle) and leaves rptr unchanged.
// -----------------------------------------------------------------------------
module stream_sync_fifo_framer #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           w_ctrl,
    input  logic [DATAWIDTH-1:0] din,
    output logic                 w_full,
    output logic                 w_error,
    output logic [ADDRWIDTH:0]   w_counter,
    input  logic                 r_en,
    output logic                 r_valid,
    output logic [DATAWIDTH-1:0] dout,
    output logic                 r_last,
    output logic                 r_error,
    output logic [ADDRWIDTH:0]   r_counter,
    output logic [ADDRWIDTH:0]   r_frames
);

    localparam int DEPTH = 1 << ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] DEPTH_W = (ADDRWIDTH+1)'(DEPTH);
    localparam logic [ADDRWIDTH:0] ONE_W   = (ADDRWIDTH+1)'(1);

    localparam logic [2:0] CMD_WRITE      = 3'd1;
    localparam logic [2:0] CMD_EOF_WRITE  = 3'd2;
    localparam logic [2:0] CMD_EOF_NOWR   = 3'd3;
    localparam logic [2:0] CMD_HEAD       = 3'd4;
    localparam logic [2:0] CMD_FINAL_HEAD = 3'd5;
    localparam logic [2:0] CMD_DISCARD    = 3'd6;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDRWIDTH:0] wptr, cptr, rptr;
    logic [ADDRWIDTH:0] wptr_nx, cptr_nx;
    logic [ADDRWIDTH:0] wptr_m1;

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]     last_flags;

    logic full;
    logic frame_empty;
    logic pop;
    logic do_write, write_last, do_mark, do_head, do_commit, w_err_nx;

    assign w_counter   = wptr - rptr;
    assign r_counter   = cptr - rptr;
    assign full        = (w_counter == DEPTH_W);
    assign frame_empty = (wptr == cptr);
    assign wptr_m1     = wptr - ONE_W;

    assign w_full  = full;
    assign r_valid = (rptr != cptr);
    assign dout    = mem[rptr[ADDRWIDTH-1:0]];
    assign r_last  = last_flags[rptr[ADDRWIDTH-1:0]];
    assign pop     = r_en && r_valid;

    // Write command decode. Full uses the pre-edge rptr, so a pop in the same
    // cycle does not make room for a write.
    always_comb begin
        wptr_nx    = wptr;
        cptr_nx    = cptr;
        do_write   = 1'b0;
        write_last = 1'b0;
        do_mark    = 1'b0;
        do_head    = 1'b0;
        do_commit  = 1'b0;
        w_err_nx   = 1'b0;
        case (w_ctrl)
            CMD_WRITE: begin
                if (full) begin
                    w_err_nx = 1'b1;
                end else begin
                    do_write = 1'b1;
                    wptr_nx  = wptr + ONE_W;
                end
            end
            CMD_EOF_WRITE: begin
                if (full) begin
                    w_err_nx = 1'b1;
                end else begin
                    do_write   = 1'b1;
                    write_last = 1'b1;
                    do_commit  = 1'b1;
                    wptr_nx    = wptr + ONE_W;
                    cptr_nx    = wptr + ONE_W;
                end
            end
            CMD_EOF_NOWR: begin
                if (frame_empty) begin
                    w_err_nx = 1'b1;
                end else begin
                    do_mark   = 1'b1;
                    do_commit = 1'b1;
                    cptr_nx   = wptr;
                end
            end
            CMD_HEAD: begin
                if (frame_empty) begin
                    w_err_nx = 1'b1;
                end else begin
                    do_head = 1'b1;
                end
            end
            CMD_FINAL_HEAD: begin
                if (frame_empty) begin
                    w_err_nx = 1'b1;
                end else begin
                    do_head   = 1'b1;
                    do_mark   = 1'b1;
                    do_commit = 1'b1;
                    cptr_nx   = wptr;
                end
            end
            CMD_DISCARD: begin
                wptr_nx = cptr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            cptr    <= '0;
            rptr    <= '0;
            w_error <= 1'b0;
            r_error <= 1'b0;
        end else begin
            wptr    <= wptr_nx;
            cptr    <= cptr_nx;
            w_error <= w_err_nx;
            r_error <= r_en && !r_valid;
            if (pop) begin
                rptr <= rptr + ONE_W;
            end
        end
    end

    // Storage is not reset. HEAD rewrites the open frame's first word, which
    // is never committed, so the reader cannot observe it mid-update. The
    // last-flag array is separate so a frame end can be marked without a
    // data rewrite.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr[ADDRWIDTH-1:0]]        <= din;
            last_flags[wptr[ADDRWIDTH-1:0]] <= write_last;
        end
        if (do_head) begin
            mem[cptr[ADDRWIDTH-1:0]] <= din;
        end
        if (do_mark) begin
            last_flags[wptr_m1[ADDRWIDTH-1:0]] <= 1'b1;
        end
    end

`ifdef STREAM_FIFO_FRAME_COUNT_EN
    logic [ADDRWIDTH:0] frames_q;
    logic               pop_last;

    assign pop_last = pop && r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_q <= '0;
        end else begin
            case ({do_commit, pop_last})
                2'b10:   frames_q <= frames_q + ONE_W;
                2'b01:   frames_q <= frames_q - ONE_W;
                default: frames_q <= frames_q;
            endcase
        end
    end

    assign r_frames = frames_q;
`else
    assign r_frames = '0;
`endif

endmodule

// File: tb/tb_stream_sync_fifo_framer.sv
// -----------------------------------------------------------------------------
// Testbench for stream_sync_fifo_framer (ADDRWIDTH=4, DATAWIDTH=8).
// The reference model keeps the open frame as a plain data queue and the
// committed stream as a queue of {last, data} words; every FIFO output is
// derived from the sizes and heads of those queues.
// -----------------------------------------------------------------------------
module tb_stream_sync_fifo_framer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

`ifdef STREAM_FIFO_FRAME_COUNT_EN
    localparam bit FRAMES_ON = 1'b1;
`else
    localparam bit FRAMES_ON = 1'b0;
`endif

    localparam logic [2:0] NOP = 3'd0, WR = 3'd1, EOFW = 3'd2, EOFN = 3'd3,
                           HEAD = 3'd4, FHEAD = 3'd5, DISC = 3'd6, RSV = 3'd7;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    w_ctrl;
    logic [DW-1:0] din;
    logic          w_full, w_error;
    logic [AW:0]   w_counter;
    logic          r_en, r_valid, r_last, r_error;
    logic [DW-1:0] dout;
    logic [AW:0]   r_counter, r_frames;

    always #5 clk = ~clk;

    stream_sync_fifo_framer #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .w_ctrl(w_ctrl), .din(din),
        .w_full(w_full), .w_error(w_error), .w_counter(w_counter),
        .r_en(r_en), .r_valid(r_valid), .dout(dout), .r_last(r_last),
        .r_error(r_error), .r_counter(r_counter), .r_frames(r_frames)
    );

    // ---------------- reference model ----------------
    logic [DW:0]   exp_q[$];   // committed words: {last, data}
    logic [DW-1:0] pend_q[$];  // open (uncommitted) frame
    logic          exp_w_err, exp_r_err;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic int model_frames();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][DW]) n++;
        return FRAMES_ON ? n : 0;
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < pend_q.size(); i++)
            exp_q.push_back({(i == pend_q.size() - 1), pend_q[i]});
        pend_q.delete();
    endfunction

    function automatic void model_step(logic [2:0] c, logic [DW-1:0] d, logic re);
        bit full_pre = (exp_q.size() + pend_q.size()) == DEPTH;
        bit open_emp = (pend_q.size() == 0);
        exp_r_err = re && (exp_q.size() == 0);
        if (re && exp_q.size() > 0) void'(exp_q.pop_front());
        exp_w_err = 1'b0;
        case (c)
            WR:    if (full_pre) exp_w_err = 1'b1; else pend_q.push_back(d);
            EOFW:  if (full_pre) exp_w_err = 1'b1;
                   else begin pend_q.push_back(d); model_commit(); end
            EOFN:  if (open_emp) exp_w_err = 1'b1; else model_commit();
            HEAD:  if (open_emp) exp_w_err = 1'b1; else pend_q[0] = d;
            FHEAD: if (open_emp) exp_w_err = 1'b1;
                   else begin pend_q[0] = d; model_commit(); end
            DISC:  pend_q.delete();
            default: ;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("w_full",    32'(w_full),    32'((exp_q.size() + pend_q.size()) == DEPTH));
        chk("w_counter", 32'(w_counter), 32'(exp_q.size() + pend_q.size()));
        chk("r_valid",   32'(r_valid),   32'(exp_q.size() > 0));
        chk("r_counter", 32'(r_counter), 32'(exp_q.size()));
        chk("r_frames",  32'(r_frames),  32'(model_frames()));
        chk("w_error",   32'(w_error),   32'(exp_w_err));
        chk("r_error",   32'(r_error),   32'(exp_r_err));
        if (exp_q.size() > 0) begin
            chk("dout",   32'(dout),   32'(exp_q[0][DW-1:0]));
            chk("r_last", 32'(r_last), 32'(exp_q[0][DW]));
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [2:0] c, input logic [DW-1:0] d, input logic re);
        w_ctrl = c;
        din    = d;
        r_en   = re;
        model_step(c, d, re);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_literals(input string tag);
        chk({tag, "_w_full"},    32'(w_full),    0);
        chk({tag, "_w_error"},   32'(w_error),   0);
        chk({tag, "_w_counter"}, 32'(w_counter), 0);
        chk({tag, "_r_valid"},   32'(r_valid),   0);
        chk({tag, "_r_error"},   32'(r_error),   0);
        chk({tag, "_r_counter"}, 32'(r_counter), 0);
        chk({tag, "_r_frames"},  32'(r_frames),  0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(NOP, '0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] seq;
        rst_n  = 1'b0;
        w_ctrl = NOP;
        din    = '0;
        r_en   = 1'b0;
        exp_w_err = 1'b0;
        exp_r_err = 1'b0;
        #2;
        check_reset_literals("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame
        step(WR, 8'h00, 0); step(WR, 8'h01, 0); step(WR, 8'h02, 0);
        chk("sf_rvalid_pre", 32'(r_valid), 0);
        step(EOFW, 8'h03, 0);
        chk("sf_rcount", 32'(r_counter), 4);
        chk("sf_dout0",  32'(dout), 32'h00);
        chk("sf_frames", 32'(r_frames), FRAMES_ON ? 1 : 0);
        for (int i = 0; i < 4; i++) step(NOP, '0, 1);
        chk("sf_frames_end", 32'(r_frames), 0);

        // Discard
        step(WR, 8'h10, 0); step(WR, 8'h11, 0); step(DISC, '0, 0);
        chk("disc_wcount", 32'(w_counter), 0);
        step(WR, 8'h20, 0); step(EOFN, '0, 0);
        chk("disc_dout",  32'(dout), 32'h20);
        chk("disc_rlast", 32'(r_last), 1);
        drain();

        // Header write-back
        step(WR, 8'h00, 0); step(WR, 8'h41, 0); step(WR, 8'h42, 0);
        step(FHEAD, 8'h03, 0);
        chk("hdr_dout", 32'(dout), 32'h03);
        drain();

        // Full
        for (int i = 0; i < 16; i++) step(WR, 8'(i), 0);
        chk("full_flag", 32'(w_full), 1);
        step(WR, 8'hEE, 0);
        chk("full_werr", 32'(w_error), 1);
        step(EOFN, '0, 0);
        chk("full_rcount", 32'(r_counter), 16);
        step(WR, 8'hEF, 1);  // pop while full: write still rejected
        drain();

        // Errors on an empty frame / empty FIFO
        step(EOFN, '0, 0); step(HEAD, 8'h55, 0); step(FHEAD, 8'h66, 0);
        step(NOP, '0, 1);
        chk("rerr_lit", 32'(r_error), 1);
        step(RSV, 8'h77, 0);

        // Wrap and concurrency
        seq = 8'h00;
        for (int f = 0; f < 40; f++)
            for (int k = 0; k < 3; k++) begin
                step((k == 2) ? EOFW : WR, seq, 1);
                seq++;
            end
        drain();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel = $urandom_range(0, 99);
            logic [2:0] c;
            if      (sel < 45) c = WR;
            else if (sel < 55) c = EOFW;
            else if (sel < 63) c = EOFN;
            else if (sel < 70) c = HEAD;
            else if (sel < 77) c = FHEAD;
            else if (sel < 81) c = DISC;
            else if (sel < 84) c = RSV;
            else               c = NOP;
            step(c, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 99) < 40));
        end

        // Asynchronous reset mid-frame
        step(WR, 8'hA0, 0); step(EOFW, 8'hA1, 0); step(WR, 8'hA2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_literals("arst");
        exp_q.delete();
        pend_q.delete();
        exp_w_err = 1'b0;
        exp_r_err = 1'b0;
        w_ctrl = NOP;
        r_en   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(NOP, '0, 0);
        step(WR, 8'hB0, 0); step(EOFN, '0, 0);
        chk("post_rst_dout", 32'(dout), 32'hB0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
